ballot_entry_ctrl: RTL and testbench
====================================

Name: ballot_entry_ctrl

Overview:
- Upstream front-end of the voting machine core.
- Synchronises and debounces raw candidate-select switches and the confirm button.
- Validates the selection as one-hot and issues exactly one clean vote transaction per confirm press over a valid/ready handshake.
- Enforces a post-vote lockout window; rejects malformed ballots with a one-cycle pulse.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on raw inputs (legal range 2..4).
- DEBOUNCE_CYCLES, 16, consecutive stable synced cycles needed to change debounced confirm (>=1).
- LOCKOUT_CYCLES, 64, idle cycles enforced after confirm release before the next ballot (0 = no lockout).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sel_raw  in  4  raw candidate switches (asynchronous)
- confirm_raw  in  1  raw confirm button (asynchronous, bouncy)
- mode  in  2  core mode: 00 vote, 01 count, 10 clear, 11 test
- vote_valid  out  1  vote transaction pending
- vote_ready  in  1  core accepts vote this cycle
- vote_onehot  out  4  selected candidate, one-hot
- vote_idx  out  2  selected candidate index 0..3
- reject  out  1  one-cycle pulse: invalid ballot or aborted vote
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst sampled high at clk edge): all sync flops, debounced confirm, edge-history flop, debounce counter, lockout counter and latches cleared; state IDLE. All outputs are 0.
- Sync: sel_raw and confirm_raw each pass through SYNC_STAGES flops. sel is not debounced.
- Debounce: counter reloads whenever the synced confirm equals confirm_db. confirm_db toggles when the counter reaches DEBOUNCE_CYCLES consecutive differing cycles. Counter width is $clog2(DEBOUNCE_CYCLES+1). Counter saturates and never wraps.
- confirm_rise = confirm_db & ~confirm_db_q. confirm_db_q updates every cycle in every state.
- FSM states: IDLE, ISSUE, RELEASE, LOCKOUT.
  - IDLE, on confirm_rise with mode==00:
    - Latch sel_sync.
    - If the latched value is one-hot: go to ISSUE.
    - Otherwise (0000, multi-hot): reject=1 for one cycle, go to RELEASE.
  - IDLE, confirm_rise in any other mode: ignored, stay IDLE.
  - ISSUE: vote_valid=1. vote_onehot and vote_idx are held stable from the latch.
    - On vote_valid & vote_ready: transfer completes; go to RELEASE next cycle.
    - If mode != 00 while waiting: vote_valid drops next cycle, reject pulses once, go to RELEASE.
  - RELEASE: wait for confirm_db==0, then go to LOCKOUT (or IDLE if LOCKOUT_CYCLES==0).
  - LOCKOUT: load counter with LOCKOUT_CYCLES-1, decrement each cycle, go to IDLE when it reaches 0. A new confirm_rise during LOCKOUT is ignored and is never queued.
- mode==10 (clear), any state: next state IDLE, lockout counter 0, vote_valid 0 next cycle, no reject pulse. A confirm still held on return needs a fresh rising edge.
- Latency: confirm_raw stable high from edge 0 gives vote_valid high at edge SYNC_STAGES+DEBOUNCE_CYCLES+1 (19 at defaults).
- vote_onehot and vote_idx are 0 whenever vote_valid is 0.
- vote_ready while vote_valid is 0 is ignored.
- Reset mid-ISSUE: the vote is lost, with no reject pulse.

Optional Feature:
- Macro BALLOT_REJECT_CNT_EN.
- Defined:
  - Extra output port reject_cnt [7:0] counts reject pulses.
  - Saturates at 255.
  - Cleared by rst or mode==10.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package ballot_pkg holds:
  - Mode encodings MODE_VOTE/COUNT/CLEAR/TEST.
  - FSM state enum.
  - Function onehot_to_idx.
- One sub-module, ballot_debounce: synchroniser plus debounce counter for a single bit, parameterised by SYNC_STAGES and DEBOUNCE_CYCLES. It is instantiated for confirm.

Test Plan (bench uses DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8, SYNC_STAGES=2):
- Clean vote: sel_raw=0100, mode=00, confirm held high, vote_ready=1 -> vote_valid high at edge 7 for exactly 1 cycle, vote_idx=2, vote_onehot=0100.
- Bounce: confirm toggles every 2 cycles for 20 cycles, then stays high -> exactly one vote_valid, issued 7 edges after final stable high.
- Invalid ballot: sel_raw=0110 then sel_raw=0000 on separate presses -> reject pulses twice, vote_valid never asserts.
- Backpressure/abort: vote_ready=0 for 10 cycles -> vote_valid held with stable vote_idx; then mode=01 -> vote_valid low next cycle, one reject pulse.
- Lockout: second press starting 3 cycles after release -> ignored, no vote; press after busy falls -> accepted.
- Clear and reset: mode=10 during LOCKOUT -> busy=0 next cycle. rst during ISSUE -> all outputs 0 next cycle. With BALLOT_REJECT_CNT_EN, reject_cnt returns to 0.

Source files
------------

// File: rtl/ballot_pkg.sv
// Shared mode encodings, FSM state type and helpers for the ballot front-end.
package ballot_pkg;

  localparam logic [1:0] MODE_VOTE  = 2'b00;
  localparam logic [1:0] MODE_COUNT = 2'b01;
  localparam logic [1:0] MODE_CLEAR = 2'b10;
  localparam logic [1:0] MODE_TEST  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (oh[i]) idx = 2'(i);
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/ballot_debounce.sv
// Single-bit synchroniser followed by a debounce counter; the output only
// follows the synced input after it has differed for DEBOUNCE_CYCLES cycles.
module ballot_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   db_q, db_d;

  // The counter stops at DEBOUNCE_CYCLES and is cleared on the toggle, so it cannot wrap.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    cnt_d  = cnt_q;
    db_d   = db_q;
    if (sync_q[SYNC_STAGES-1] == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
      db_d  = ~db_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  assign dout = db_q;

endmodule

// File: rtl/ballot_entry_ctrl.sv
// Ballot entry front-end: syncs switches, debounces confirm, issues one vote per press.
// Optional BALLOT_REJECT_CNT_EN adds a saturating reject_cnt output.
module ballot_entry_ctrl
  import ballot_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCKOUT_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sel_raw,
  input  logic       confirm_raw,
  input  logic [1:0] mode,
  output logic       vote_valid,
  input  logic       vote_ready,
  output logic [3:0] vote_onehot,
  output logic [1:0] vote_idx,
  output logic       reject,
  output logic       busy
`ifdef BALLOT_REJECT_CNT_EN
  ,
  output logic [7:0] reject_cnt
`endif
);

  localparam int LK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LK_W-1:0] LK_LOAD = (LOCKOUT_CYCLES > 0) ? LK_W'(LOCKOUT_CYCLES - 1) : '0;

  logic [SYNC_STAGES-1:0][3:0] sel_sync_q, sel_sync_d;
  logic [3:0]                  sel_sync;
  logic                        confirm_db, confirm_db_q, confirm_rise;
  state_e                      state_q, state_d;
  logic [3:0]                  latch_q, latch_d;
  logic [LK_W-1:0]             lk_q, lk_d;
  logic                        reject_q, reject_d;

  ballot_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_confirm_db (
    .clk (clk),
    .rst (rst),
    .din (confirm_raw),
    .dout(confirm_db)
  );

  assign sel_sync     = sel_sync_q[SYNC_STAGES-1];
  assign confirm_rise = confirm_db & ~confirm_db_q;

  always_comb begin
    sel_sync_d = {sel_sync_q[SYNC_STAGES-2:0], sel_raw};
    state_d    = state_q;
    latch_d    = latch_q;
    lk_d       = lk_q;
    reject_d   = 1'b0;
    if (mode == MODE_CLEAR) begin
      state_d = ST_IDLE;
      lk_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (confirm_rise && mode == MODE_VOTE) begin
            latch_d = sel_sync;
            if (is_onehot(sel_sync)) begin
              state_d = ST_ISSUE;
            end else begin
              reject_d = 1'b1;
              state_d  = ST_RELEASE;
            end
          end
        end
        // A completed handshake wins over a same-cycle abort.
        ST_ISSUE: begin
          if (vote_ready) begin
            state_d = ST_RELEASE;
          end else if (mode == MODE_COUNT || mode == MODE_TEST) begin
            reject_d = 1'b1;
            state_d  = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!confirm_db) begin
            if (LOCKOUT_CYCLES == 0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_LOCKOUT;
              lk_d    = LK_LOAD;
            end
          end
        end
        ST_LOCKOUT: begin
          if (lk_q == '0) state_d = ST_IDLE;
          else            lk_d    = lk_q - 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_sync_q   <= '0;
      confirm_db_q <= 1'b0;
      state_q      <= ST_IDLE;
      latch_q      <= '0;
      lk_q         <= '0;
      reject_q     <= 1'b0;
    end else begin
      sel_sync_q   <= sel_sync_d;
      confirm_db_q <= confirm_db;
      state_q      <= state_d;
      latch_q      <= latch_d;
      lk_q         <= lk_d;
      reject_q     <= reject_d;
    end
  end

`ifdef BALLOT_REJECT_CNT_EN
  logic [7:0] rcnt_q, rcnt_d;

  always_comb begin
    rcnt_d = rcnt_q;
    if (mode == MODE_CLEAR)                  rcnt_d = '0;
    else if (reject_d && rcnt_q != 8'hFF)    rcnt_d = rcnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) rcnt_q <= '0;
    else     rcnt_q <= rcnt_d;
  end

  assign reject_cnt = rcnt_q;
`endif

  assign vote_valid  = (state_q == ST_ISSUE);
  assign vote_onehot = vote_valid ? latch_q : 4'd0;
  assign vote_idx    = vote_valid ? onehot_to_idx(latch_q) : 2'd0;
  assign reject      = reject_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ballot_entry_ctrl.sv
// Bench for ballot_entry_ctrl: table-driven presses, timed corner sequences and
// randomized presses scored against a transaction-level ballot model.
module tb_ballot_entry_ctrl;

  logic       clk, rst;
  logic [3:0] sel_raw;
  logic       confirm_raw;
  logic [1:0] mode;
  logic       vote_valid, vote_ready;
  logic [3:0] vote_onehot;
  logic [1:0] vote_idx;
  logic       reject, busy;
`ifdef BALLOT_REJECT_CNT_EN
  logic [7:0] reject_cnt;
`endif

  ballot_entry_ctrl #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .LOCKOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sel_raw    (sel_raw),
    .confirm_raw(confirm_raw),
    .mode       (mode),
    .vote_valid (vote_valid),
    .vote_ready (vote_ready),
    .vote_onehot(vote_onehot),
    .vote_idx   (vote_idx),
    .reject     (reject),
    .busy       (busy)
`ifdef BALLOT_REJECT_CNT_EN
    ,
    .reject_cnt (reject_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_fail;
  int n_xfer, n_rej;
  logic [1:0] last_idx;
  logic [3:0] last_oh;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction monitor plus output invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (vote_valid && vote_ready) begin
        n_xfer++;
        last_idx = vote_idx;
        last_oh  = vote_onehot;
      end
      if (reject) n_rej++;
      if (!vote_valid) check("idle_outputs_zero", {30'd0, |vote_onehot, |vote_idx}, 32'd0);
      else             check("onehot_matches_idx", {28'd0, vote_onehot}, {28'd0, 4'b0001 << vote_idx});
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 100) begin tick(); k++; end
    if (busy) check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!vote_valid && k < 40) begin tick(); k++; end
    check(name, {31'd0, vote_valid}, 32'd1);
  endtask

  task automatic do_press(input logic [3:0] s, input logic [1:0] m, input int hold);
    sel_raw = s; mode = m; confirm_raw = 1'b1;
    settle(hold);
    confirm_raw = 1'b0;
    wait_idle();
    mode = 2'b00;
    settle(12);
  endtask

  typedef struct {
    logic [3:0] sel;
    logic       exp_vote;
    logic [1:0] exp_idx;
  } press_t;

  press_t tbl[8];
  int first, nv, x0, r0, base_rej;
  logic [1:0] cidx;
  logic [3:0] coh;

  initial begin
    tbl[0] = '{4'b0100, 1'b1, 2'd2};
    tbl[1] = '{4'b0001, 1'b1, 2'd0};
    tbl[2] = '{4'b1000, 1'b1, 2'd3};
    tbl[3] = '{4'b0010, 1'b1, 2'd1};
    tbl[4] = '{4'b0110, 1'b0, 2'd0};
    tbl[5] = '{4'b0000, 1'b0, 2'd0};
    tbl[6] = '{4'b1111, 1'b0, 2'd0};
    tbl[7] = '{4'b1001, 1'b0, 2'd0};

    n_chk = 0; n_fail = 0; n_xfer = 0; n_rej = 0;
    rst = 1'b1; sel_raw = 4'd0; confirm_raw = 1'b0; mode = 2'b00; vote_ready = 1'b1;
    settle(3);
    check("reset_outputs", {22'd0, vote_valid, vote_onehot, vote_idx, reject, busy}, 32'd0);
`ifdef BALLOT_REJECT_CNT_EN
    check("reset_reject_cnt", {24'd0, reject_cnt}, 32'd0);
`endif
    rst = 1'b0;
    settle(2);

    // Clean vote: valid must rise at edge 7 and last one cycle.
    sel_raw = 4'b0100; confirm_raw = 1'b1; first = -1; nv = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (vote_valid) begin
        if (first < 0) begin first = k; cidx = vote_idx; coh = vote_onehot; end
        nv++;
      end
    end
    check("clean_first_edge", first, 7);
    check("clean_valid_cycles", nv, 1);
    check("clean_idx", {30'd0, cidx}, 32'd2);
    check("clean_onehot", {28'd0, coh}, 32'h4);
    confirm_raw = 1'b0; wait_idle(); settle(12);

    // Bounce: 2-cycle toggles for 20 cycles, then stable high from edge 20.
    sel_raw = 4'b0010; first = -1; nv = 0;
    for (int k = 0; k < 40; k++) begin
      confirm_raw = (k >= 20) ? 1'b1 : (((k / 2) % 2) == 0);
      tick();
      if (vote_valid) begin
        if (first < 0) first = k;
        nv++;
      end
    end
    check("bounce_first_edge", first, 27);
    check("bounce_valid_cycles", nv, 1);
    confirm_raw = 1'b0; wait_idle(); settle(12);

    // Table of single presses with ready held high.
    for (int i = 0; i < 8; i++) begin
      x0 = n_xfer; r0 = n_rej;
      do_press(tbl[i].sel, 2'b00, 20);
      check($sformatf("tbl%0d_xfers", i), n_xfer - x0, {31'd0, tbl[i].exp_vote});
      check($sformatf("tbl%0d_rejects", i), n_rej - r0, {31'd0, ~tbl[i].exp_vote});
      if (tbl[i].exp_vote) begin
        check($sformatf("tbl%0d_idx", i), {30'd0, last_idx}, {30'd0, tbl[i].exp_idx});
        check($sformatf("tbl%0d_onehot", i), {28'd0, last_oh}, {28'd0, tbl[i].sel});
      end
    end

    // Backpressure then abort via mode change.
    sel_raw = 4'b0001; vote_ready = 1'b0; confirm_raw = 1'b1; x0 = n_xfer;
    wait_valid("bp_valid_seen");
    r0 = n_rej;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_valid_held", {29'd0, vote_valid, vote_idx}, {29'd0, 1'b1, 2'd0});
    end
    mode = 2'b01;
    tick();
    check("abort_valid_low", {31'd0, vote_valid}, 32'd0);
    check("abort_reject_high", {31'd0, reject}, 32'd1);
    tick();
    check("abort_reject_pulse", {31'd0, reject}, 32'd0);
    check("abort_reject_count", n_rej - r0, 32'd1);
    check("abort_no_xfer", n_xfer - x0, 32'd0);
    mode = 2'b00; vote_ready = 1'b1; confirm_raw = 1'b0;
    wait_idle(); settle(12);

    // Lockout: a press that matures while locked out is dropped, not queued.
    sel_raw = 4'b0010; confirm_raw = 1'b1; settle(20);
    confirm_raw = 1'b0; x0 = n_xfer; r0 = n_rej;
    settle(6);
    confirm_raw = 1'b1;
    settle(8);
    check("lockout_busy_at_rise", {31'd0, busy}, 32'd1);
    settle(22);
    check("lockout_busy_cleared", {31'd0, busy}, 32'd0);
    check("lockout_no_xfer", n_xfer - x0, 32'd0);
    check("lockout_no_reject", n_rej - r0, 32'd0);
    confirm_raw = 1'b0; settle(12);
    x0 = n_xfer;
    do_press(4'b1000, 2'b00, 20);
    check("after_lockout_xfer", n_xfer - x0, 32'd1);
    check("after_lockout_idx", {30'd0, last_idx}, 32'd3);

    // Clear during lockout.
    sel_raw = 4'b0001; confirm_raw = 1'b1; settle(20);
    confirm_raw = 1'b0; r0 = n_rej;
    settle(10);
    check("clear_lk_busy_before", {31'd0, busy}, 32'd1);
    mode = 2'b10;
    tick();
    check("clear_lk_busy_after", {31'd0, busy}, 32'd0);
    tick();
    check("clear_lk_no_reject", n_rej - r0, 32'd0);
    mode = 2'b00; settle(12);

    // Clear during ISSUE; still-held confirm must not re-issue.
    sel_raw = 4'b1000; vote_ready = 1'b0; confirm_raw = 1'b1;
    wait_valid("clr_issue_valid_seen");
    r0 = n_rej;
    mode = 2'b10;
    tick();
    check("clr_issue_outputs", {25'd0, vote_valid, vote_onehot, busy}, 32'd0);
    tick();
    mode = 2'b00; vote_ready = 1'b1; nv = 0;
    for (int k = 0; k < 12; k++) begin tick(); if (vote_valid) nv++; end
    check("clr_issue_no_reissue", nv, 0);
    check("clr_issue_no_reject", n_rej - r0, 32'd0);
`ifdef BALLOT_REJECT_CNT_EN
    check("clr_reject_cnt_zero", {24'd0, reject_cnt}, 32'd0);
`endif
    confirm_raw = 1'b0; settle(15);

    // Reset during ISSUE: vote lost, everything back to zero.
    do_press(4'b0110, 2'b00, 20);
    sel_raw = 4'b0100; vote_ready = 1'b0; confirm_raw = 1'b1;
    wait_valid("rst_issue_valid_seen");
    rst = 1'b1;
    tick();
    check("rst_issue_outputs", {22'd0, vote_valid, vote_onehot, vote_idx, reject, busy}, 32'd0);
`ifdef BALLOT_REJECT_CNT_EN
    check("rst_reject_cnt_zero", {24'd0, reject_cnt}, 32'd0);
`endif
    rst = 1'b0; confirm_raw = 1'b0; vote_ready = 1'b1; settle(15);

    // Randomized presses against a per-ballot model.
    base_rej = n_rej;
    for (int it = 0; it < 16; it++) begin
      logic [3:0] s;
      logic [1:0] m;
      int nb, ex, er;
      s = ($urandom_range(0, 1) == 1) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
      m = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 2'b01 : 2'b11) : 2'b00;
      ex = (m == 2'b00 && $countones(s) == 1) ? 1 : 0;
      er = (m == 2'b00 && $countones(s) != 1) ? 1 : 0;
      x0 = n_xfer; r0 = n_rej;
      sel_raw = s; mode = m;
      nb = $urandom_range(0, 4);
      for (int b = 0; b < nb; b++) begin
        confirm_raw = ~confirm_raw;
        settle($urandom_range(1, 3));
      end
      confirm_raw = 1'b1;
      for (int k = 0; k < 30; k++) begin
        vote_ready = (k >= 25) ? 1'b1 : 1'($urandom_range(0, 1));
        tick();
      end
      vote_ready = 1'b1; confirm_raw = 1'b0;
      wait_idle(); mode = 2'b00; settle(12);
      check($sformatf("rnd%0d_xfers", it), n_xfer - x0, ex);
      check($sformatf("rnd%0d_rejects", it), n_rej - r0, er);
      if (ex == 1) check($sformatf("rnd%0d_idx", it), {30'd0, last_idx}, $clog2(s));
    end
`ifdef BALLOT_REJECT_CNT_EN
    check("rnd_reject_cnt", {24'd0, reject_cnt},
          ((n_rej - base_rej) > 255) ? 255 : (n_rej - base_rej));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
